// File: rtl/wb_m2_arbiter_pkg.sv
// Shared types and constants for the m2 two-master Wishbone arbiter.
// Holds the arbiter state encoding, one-hot grant codes and the single-beat burst length.
package wb_m2_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam logic [9:0] BL_SINGLE = 10'd1;

endpackage

// File: rtl/wb_m2_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker (module wb_rr_pick2).
// On a tie the master that was not granted last wins.
module wb_rr_pick2
    import wb_m2_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_win
);

    always_comb begin
        o_win = GNT_NONE;
        case (i_req)
            2'b01:   o_win = GNT_M0;
            2'b10:   o_win = GNT_M1;
            2'b11:   o_win = i_last ? GNT_M0 : GNT_M1;
            default: o_win = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/wb_m2_arbiter.sv
// Registered two-master Wishbone arbiter for the m2 port: whole-transaction grants with round-robin.
// Optional slave timeout is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_m2_arbiter
    import wb_m2_arbiter_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int BL_W        = 10,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_adr_i,
    input  logic [DATA_W-1:0] m0_dat_i,
    input  logic [3:0]        m0_sel_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic [DATA_W-1:0] m0_dat_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic              m1_bry_i,
    input  logic [ADDR_W-1:0] m1_adr_i,
    input  logic [DATA_W-1:0] m1_dat_i,
    input  logic [3:0]        m1_sel_i,
    input  logic [BL_W-1:0]   m1_bl_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [DATA_W-1:0] m1_dat_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic              s_bry_o,
    output logic [ADDR_W-1:0] s_adr_o,
    output logic [DATA_W-1:0] s_dat_o,
    output logic [3:0]        s_sel_o,
    output logic [BL_W-1:0]   s_bl_o,
    input  logic [DATA_W-1:0] s_dat_i,
    input  logic              s_ack_i,
    input  logic              s_lack_i,
    input  logic              s_err_i,
    output logic [1:0]        grant_o
);

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic            r_last;          // 1: m1 held the most recent grant
    logic [BL_W-1:0] r_beats;
    logic [BL_W-1:0] w_beats_nxt;
    logic [1:0]      w_req;
    logic [1:0]      w_win;
    logic            w_own_cyc;
    logic            w_done;
    logic            w_tmo;

    assign w_req     = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
    assign w_own_cyc = (r_state == ARB_GNT0) ? m0_cyc_i : m1_cyc_i;

    wb_rr_pick2 u_pick (
        .i_req  (w_req),
        .i_last (r_last),
        .o_win  (w_win)
    );

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] r_tmo;

    // Held at zero while idle so every grant starts counting from zero.
    always_ff @(posedge clk) begin
        if (reset || r_state == ARB_IDLE || s_ack_i)
            r_tmo <= '0;
        else
            r_tmo <= r_tmo + 1'b1;
    end

    assign w_tmo = (r_state != ARB_IDLE) && (r_tmo == TMO_W'(TIMEOUT_CYC));
`else
    // Without the timeout the slave is waited on indefinitely.
    assign w_tmo = (TIMEOUT_CYC < 0);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_beats_nxt = r_beats;
        w_done      = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_win == GNT_M0) begin
                    w_state_nxt = ARB_GNT0;
                    w_beats_nxt = BL_W'(BL_SINGLE);
                end else if (w_win == GNT_M1) begin
                    w_state_nxt = ARB_GNT1;
                    w_beats_nxt = (m1_bl_i == '0) ? BL_W'(BL_SINGLE) : m1_bl_i;
                end
            end
            ARB_GNT0, ARB_GNT1: begin
                w_done = (s_ack_i && r_beats == BL_W'(1)) || s_lack_i || s_err_i
                         || w_tmo || !w_own_cyc;
                if (s_ack_i)
                    w_beats_nxt = r_beats - 1'b1;
                if (w_done)
                    w_state_nxt = ARB_IDLE;
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_beats <= '0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_beats <= w_beats_nxt;
            if (r_state == ARB_IDLE && w_win != GNT_NONE)
                r_last <= w_win[1];
        end
    end

    // Bus and responses follow the registered grant; only the owner sees ack/err.
    always_comb begin
        grant_o  = GNT_NONE;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_bry_o  = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_bl_o   = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (r_state)
            ARB_GNT0: begin
                grant_o  = GNT_M0;
                s_cyc_o  = m0_cyc_i & ~w_tmo;
                s_stb_o  = m0_stb_i & ~w_tmo;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_bl_o   = BL_W'(BL_SINGLE);
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | w_tmo;
            end
            ARB_GNT1: begin
                grant_o  = GNT_M1;
                s_cyc_o  = m1_cyc_i & ~w_tmo;
                s_stb_o  = m1_stb_i & ~w_tmo;
                s_we_o   = m1_we_i;
                s_bry_o  = m1_bry_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_bl_o   = m1_bl_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | w_tmo;
            end
            default: ;
        endcase
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_m2_arbiter.sv
// Self-checking bench for wb_m2_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level arbitration model.
module tb_wb_m2_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int BL_W   = 10;
    localparam int TB_TMO = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              m0_cyc_i, m0_stb_i, m0_we_i;
    logic [ADDR_W-1:0] m0_adr_i;
    logic [DATA_W-1:0] m0_dat_i;
    logic [3:0]        m0_sel_i;
    logic              m0_ack_o, m0_err_o;
    logic [DATA_W-1:0] m0_dat_o;
    logic              m1_cyc_i, m1_stb_i, m1_we_i, m1_bry_i;
    logic [ADDR_W-1:0] m1_adr_i;
    logic [DATA_W-1:0] m1_dat_i;
    logic [3:0]        m1_sel_i;
    logic [BL_W-1:0]   m1_bl_i;
    logic              m1_ack_o, m1_err_o;
    logic [DATA_W-1:0] m1_dat_o;
    logic              s_cyc_o, s_stb_o, s_we_o, s_bry_o;
    logic [ADDR_W-1:0] s_adr_o;
    logic [DATA_W-1:0] s_dat_o;
    logic [3:0]        s_sel_o;
    logic [BL_W-1:0]   s_bl_o;
    logic [DATA_W-1:0] s_dat_i;
    logic              s_ack_i, s_lack_i, s_err_i;
    logic [1:0]        grant_o;

    int total = 0;
    int bad   = 0;

    wb_m2_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BL_W(BL_W), .TIMEOUT_CYC(TB_TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_bry_i(m1_bry_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_bl_i(m1_bl_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_bry_o(s_bry_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_bl_o(s_bl_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_lack_i(s_lack_i), .s_err_i(s_err_i),
        .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_bry_i = 0; m1_adr_i = '0; m1_dat_i = '0;
        m1_sel_i = '0; m1_bl_i = '0;
        s_dat_i = '0; s_ack_i = 0; s_lack_i = 0; s_err_i = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1; m1_bl_i = 10'd4;
        s_ack_i = 1; s_err_i = 1;
        step(); step(); #1;
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL rst_grant got=%b want=00", grant_o); end
        total++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin bad++; $display("FAIL rst_cycstb got=%b%b want=00", s_cyc_o, s_stb_o); end
        total++; if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0) begin bad++; $display("FAIL rst_resp got=%b want=0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}); end
        total++; if (s_bl_o !== '0 || s_adr_o !== '0) begin bad++; $display("FAIL rst_bus got bl=%0d adr=%h want 0", s_bl_o, s_adr_o); end
        reset = 0;
        idle_inputs();
        step();
    endtask

    task automatic test_m0_read();
        idle_inputs();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h3000_0000; m0_sel_i = 4'hF; #1;
        total++; if (s_stb_o !== 1'b0) begin bad++; $display("FAIL m0_stb_early got=%b want=0", s_stb_o); end
        step(); #1;
        total++; if (s_stb_o !== 1'b1) begin bad++; $display("FAIL m0_stb_rise got=%b want=1", s_stb_o); end
        total++; if (s_adr_o !== 32'h3000_0000) begin bad++; $display("FAIL m0_adr got=%h want=30000000", s_adr_o); end
        total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL m0_grant got=%b want=01", grant_o); end
        total++; if (s_bl_o !== 10'd1) begin bad++; $display("FAIL m0_bl got=%0d want=1", s_bl_o); end
        s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF; #1;
        total++; if (m0_ack_o !== 1'b1) begin bad++; $display("FAIL m0_ack got=%b want=1", m0_ack_o); end
        total++; if (m0_dat_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL m0_dat got=%h want=deadbeef", m0_dat_o); end
        total++; if (m1_ack_o !== 1'b0) begin bad++; $display("FAIL m0_m1ack got=%b want=0", m1_ack_o); end
        step();
        idle_inputs(); #1;
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL m0_release got=%b want=00", grant_o); end
        step();
    endtask

    task automatic test_m1_burst();
        logic [DATA_W-1:0] d;
        int acks = 0;
        idle_inputs();
        m1_cyc_i = 1; m1_stb_i = 1; m1_bl_i = 10'd4; m1_bry_i = 1; m1_adr_i = 32'h8000_0040;
        step(); #1;
        total++; if (grant_o !== 2'b10 || s_bl_o !== 10'd4) begin bad++; $display("FAIL b4_grant got=%b bl=%0d want=10 bl=4", grant_o, s_bl_o); end
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            s_ack_i = 1; s_dat_i = d;
            if (i == 1) begin m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h3000_0010; end
            #1;
            if (m1_ack_o === 1'b1) acks++;
            total++; if (grant_o !== 2'b10) begin bad++; $display("FAIL b4_hold beat=%0d got=%b want=10", i, grant_o); end
            total++; if (m0_ack_o !== 1'b0) begin bad++; $display("FAIL b4_m0ack beat=%0d got=%b want=0", i, m0_ack_o); end
            total++; if (m1_dat_o !== d) begin bad++; $display("FAIL b4_dat beat=%0d got=%h want=%h", i, m1_dat_o, d); end
            step();
        end
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; #1;
        total++; if (acks !== 4) begin bad++; $display("FAIL b4_acks got=%0d want=4", acks); end
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL b4_release got=%b want=00", grant_o); end
        step(); #1;
        total++; if (grant_o !== 2'b01 || s_adr_o !== 32'h3000_0010) begin bad++; $display("FAIL b4_m0wait got=%b adr=%h want=01 30000010", grant_o, s_adr_o); end
        s_ack_i = 1; #1;
        total++; if (m0_ack_o !== 1'b1) begin bad++; $display("FAIL b4_m0ack_after got=%b want=1", m0_ack_o); end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_back_to_back();
        logic [13:0] seq;
        logic [1:0]  e;
        seq = 14'b00_01_00_10_00_01_00;
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1; m1_bl_i = 10'd1; s_ack_i = 1;
        for (int i = 0; i < 7; i++) begin
            e = seq[13 - 2*i -: 2];
            #1;
            total++; if (grant_o !== e) begin bad++; $display("FAIL tie_grant cyc=%0d got=%b want=%b", i, grant_o, e); end
            total++; if ({m1_ack_o, m0_ack_o} !== e) begin bad++; $display("FAIL tie_ack cyc=%0d got=%b want=%b", i, {m1_ack_o, m0_ack_o}, e); end
            step();
        end
        idle_inputs();
        step(); step();
    endtask

    task automatic test_lack();
        idle_inputs();
        m1_cyc_i = 1; m1_stb_i = 1; m1_bl_i = 10'd8;
        step();
        for (int i = 0; i < 3; i++) begin
            s_ack_i = 1; s_lack_i = (i == 2); #1;
            total++; if (grant_o !== 2'b10 || m1_ack_o !== 1'b1) begin bad++; $display("FAIL lack_beat=%0d got grant=%b ack=%b want 10 1", i, grant_o, m1_ack_o); end
            step();
        end
        s_ack_i = 0; s_lack_i = 0; m1_bl_i = 10'd2; #1;
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL lack_release got=%b want=00", grant_o); end
        step();
        s_ack_i = 1; #1;
        total++; if (grant_o !== 2'b10) begin bad++; $display("FAIL lack_regrant got=%b want=10", grant_o); end
        step(); #1;
        total++; if (grant_o !== 2'b10) begin bad++; $display("FAIL lack_reload_hold got=%b want=10", grant_o); end
        step();
        s_ack_i = 0; m1_bl_i = 10'd0; #1;
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL lack_reload_end got=%b want=00", grant_o); end
        step();
        s_ack_i = 1; #1;
        total++; if (grant_o !== 2'b10 || s_bl_o !== 10'd0) begin bad++; $display("FAIL bl0_grant got=%b bl=%0d want=10 0", grant_o, s_bl_o); end
        step();
        idle_inputs(); #1;
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL bl0_single got=%b want=00", grant_o); end
        step();
    endtask

    task automatic test_err_abort();
        idle_inputs();
        m1_cyc_i = 1; m1_stb_i = 1; m1_bl_i = 10'd4;
        step();
        s_ack_i = 1;
        step();
        s_ack_i = 0; s_err_i = 1; #1;
        total++; if (m1_err_o !== 1'b1 || m0_err_o !== 1'b0) begin bad++; $display("FAIL err_route got m1=%b m0=%b want 1 0", m1_err_o, m0_err_o); end
        total++; if (m1_ack_o !== 1'b0) begin bad++; $display("FAIL err_noack got=%b want=0", m1_ack_o); end
        step();
        s_err_i = 0; #1;
        total++; if (grant_o !== 2'b00 || m1_err_o !== 1'b0) begin bad++; $display("FAIL err_release got=%b err=%b want=00 0", grant_o, m1_err_o); end
        idle_inputs();
        m0_cyc_i = 1; m0_stb_i = 1;
        step();
        m0_cyc_i = 0; m0_stb_i = 0; #1;
        total++; if (s_cyc_o !== 1'b0 || grant_o !== 2'b01) begin bad++; $display("FAIL abort_cyc got cyc=%b grant=%b want 0 01", s_cyc_o, grant_o); end
        step(); #1;
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL abort_release got=%b want=00", grant_o); end
        m0_cyc_i = 1; m0_stb_i = 1;
        step();
        m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 1; #1;
        total++; if (m0_ack_o !== 1'b1) begin bad++; $display("FAIL ackdrop_ack got=%b want=1", m0_ack_o); end
        step();
        s_ack_i = 0; #1;
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL ackdrop_release got=%b want=00", grant_o); end
        step();
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int seen = -1;
        idle_inputs();
        m0_cyc_i = 1; m0_stb_i = 1;
        step();
        for (int n = 0; n < 40; n++) begin
            #1;
            if (m0_err_o === 1'b1 && seen < 0) begin
                seen = n;
                total++; if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL tmo_cyc got=%b want=0", s_cyc_o); end
            end
            step();
            if (seen >= 0) break;
        end
        total++; if (seen !== TB_TMO) begin bad++; $display("FAIL tmo_cycle got=%0d want=%0d", seen, TB_TMO); end
        m0_cyc_i = 0; m0_stb_i = 0; #1;
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL tmo_release got=%b want=00", grant_o); end
        step();
    endtask
`endif

    task automatic test_reset_mid();
        idle_inputs();
        m1_cyc_i = 1; m1_stb_i = 1; m1_bl_i = 10'd8;
        step();
        s_ack_i = 1;
        step(); step();
        s_ack_i = 0; reset = 1;
        step();
        reset = 0; s_ack_i = 1; s_err_i = 0;
        m0_cyc_i = 1; m0_stb_i = 1; #1;
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL rmid_grant got=%b want=00", grant_o); end
        total++; if ({s_cyc_o, s_stb_o, m1_ack_o, m1_err_o, m0_ack_o} !== 5'b0) begin bad++; $display("FAIL rmid_outs got=%b want=00000", {s_cyc_o, s_stb_o, m1_ack_o, m1_err_o, m0_ack_o}); end
        total++; if (s_bl_o !== '0 || s_adr_o !== '0) begin bad++; $display("FAIL rmid_bus got bl=%0d adr=%h want 0", s_bl_o, s_adr_o); end
        step(); #1;
        total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL rmid_tie got=%b want=01", grant_o); end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_random();
        int mo, mlast, mrem, win;
        logic r0, r1, own, fin;
        logic [1:0] e_gnt;
        logic e_cyc, e_stb, e_a0, e_a1, e_e0, e_e1;
        logic [ADDR_W-1:0] e_adr;
        logic [BL_W-1:0] e_bl;
        do_reset();
        mo = 0; mlast = 2; mrem = 0;
        for (int c = 0; c < 600; c++) begin
            m0_cyc_i = ($urandom_range(0, 3) != 0);
            m0_stb_i = m0_cyc_i & ($urandom_range(0, 3) != 0);
            m0_adr_i = $urandom; m0_we_i = $urandom_range(0, 1);
            m1_cyc_i = ($urandom_range(0, 3) != 0);
            m1_stb_i = m1_cyc_i & ($urandom_range(0, 3) != 0);
            m1_adr_i = $urandom; m1_bl_i = BL_W'($urandom_range(0, 5));
            s_ack_i = ($urandom_range(0, 3) != 0);
            s_lack_i = ($urandom_range(0, 15) == 0);
            s_err_i = ($urandom_range(0, 15) == 0);
            s_dat_i = $urandom;
            #1;
            e_gnt = (mo == 1) ? 2'b01 : (mo == 2) ? 2'b10 : 2'b00;
            e_cyc = (mo == 1) ? m0_cyc_i : (mo == 2) ? m1_cyc_i : 1'b0;
            e_stb = (mo == 1) ? m0_stb_i : (mo == 2) ? m1_stb_i : 1'b0;
            e_adr = (mo == 1) ? m0_adr_i : (mo == 2) ? m1_adr_i : '0;
            e_bl  = (mo == 1) ? 10'd1 : (mo == 2) ? m1_bl_i : '0;
            e_a0 = (mo == 1) && s_ack_i; e_a1 = (mo == 2) && s_ack_i;
            e_e0 = (mo == 1) && s_err_i; e_e1 = (mo == 2) && s_err_i;
            total++; if (grant_o !== e_gnt) begin bad++; $display("FAIL rnd_grant c=%0d got=%b want=%b", c, grant_o, e_gnt); end
            total++; if ({s_cyc_o, s_stb_o} !== {e_cyc, e_stb}) begin bad++; $display("FAIL rnd_cycstb c=%0d got=%b%b want=%b%b", c, s_cyc_o, s_stb_o, e_cyc, e_stb); end
            total++; if (s_adr_o !== e_adr || s_bl_o !== e_bl) begin bad++; $display("FAIL rnd_bus c=%0d got=%h/%0d want=%h/%0d", c, s_adr_o, s_bl_o, e_adr, e_bl); end
            total++; if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== {e_a0, e_a1, e_e0, e_e1}) begin bad++; $display("FAIL rnd_resp c=%0d got=%b want=%b", c, {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, {e_a0, e_a1, e_e0, e_e1}); end
            if (mo == 0) begin
                r0 = m0_cyc_i && m0_stb_i;
                r1 = m1_cyc_i && m1_stb_i;
                if (r0 && r1) win = (mlast == 2) ? 1 : 2;
                else if (r0) win = 1;
                else if (r1) win = 2;
                else win = 0;
                if (win != 0) begin
                    mo = win; mlast = win;
                    mrem = (win == 1) ? 1 : ((m1_bl_i == 0) ? 1 : int'(m1_bl_i));
                end
            end else begin
                own = (mo == 1) ? m0_cyc_i : m1_cyc_i;
                fin = (s_ack_i && mrem == 1) || s_lack_i || s_err_i || !own;
                if (s_ack_i) mrem--;
                if (fin) mo = 0;
            end
            step();
        end
        idle_inputs();
        step(); step();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        step(); step();
        test_reset();
        test_m0_read();
        test_m1_burst();
        test_back_to_back();
        test_lack();
        test_err_abort();
`ifdef WB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_m2_arbiter.md
# wb_m2_arbiter

Registered two-master Wishbone arbiter for the core's m2 data port. It sits directly downstream of the core's uncached "others" port (master 0) and the L1 data cache refill/writeback port (master 1), and drives the single m2 master port towards the SoC. It grants whole transactions, including bursts, with round-robin fairness. It tracks burst beats from the granted burst length, and it never routes an ack or err to a master that does not hold the grant.

## Interface
- DATA_W, 32, data bus width
- ADDR_W, 32, address width
- BL_W, 10, burst-length field width
- TIMEOUT_CYC, 1023, cycles without ack before a forced error (only with the timeout feature)

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  others-port request; always single beat
- m0_adr_i  in  ADDR_W  others-port address
- m0_dat_i  in  DATA_W  others-port write data
- m0_sel_i  in  4  others-port byte select
- m0_ack_o, m0_err_o  out  1 each  others-port response
- m0_dat_o  out  DATA_W  others-port read data
- m1_cyc_i, m1_stb_i, m1_we_i, m1_bry_i  in  1 each  dcache request
- m1_adr_i  in  ADDR_W  dcache address
- m1_dat_i  in  DATA_W  dcache write data
- m1_sel_i  in  4  dcache byte select
- m1_bl_i  in  BL_W  dcache burst length
- m1_ack_o, m1_err_o  out  1 each  dcache response
- m1_dat_o  out  DATA_W  dcache read data
- s_cyc_o, s_stb_o, s_we_o, s_bry_o  out  1 each  SoC m2 control
- s_adr_o  out  ADDR_W  SoC m2 address
- s_dat_o  out  DATA_W  SoC m2 write data
- s_sel_o  out  4  SoC m2 byte select
- s_bl_o  out  BL_W  SoC m2 burst length
- s_dat_i  in  DATA_W  SoC read data
- s_ack_i, s_lack_i, s_err_i  in  1 each  SoC ack, last ack, error
- grant_o  out  2  one-hot grant: bit0 = m0, bit1 = m1

## Operation
- **States**
  - IDLE: no master granted.
  - GNT0: m0 owns the slave.
  - GNT1: m1 owns the slave.
- **Arbitration (IDLE only)**
  - A master requests when cyc & stb.
  - Sole requester wins.
  - If both request, the master not granted last wins. The `last` register resets to m1, so m0 wins the first tie.
  - Winner is registered. GNTx is entered the next cycle.
- **Beat count on grant entry**
  - Load `beats` with 1 for m0, or m1_bl_i for m1. A burst length of 0 is treated as 1.
  - Each s_ack_i decrements `beats`.
- **Release to IDLE.** The cycle after any of the following:
  - s_ack_i with beats==1;
  - s_lack_i;
  - s_err_i;
  - the granted master deasserting cyc (abort).
- **Routing**
  - While granted, s_* outputs mirror the granted master's inputs combinationally. s_bl_o is 1 for m0.
  - s_ack_i, s_err_i and s_dat_i go only to the granted master. The other master sees ack=0 and err=0; its dat_o is don't-care, driven with s_dat_i.
- **Reset values**
  - All s_* outputs 0.
  - m0/m1 ack/err 0.
  - grant_o = 2'b00; state IDLE; beats 0; last = m1.
- **Reset mid-burst:** outputs drop to 0 in the next cycle. No completion is reported to either master.

## Timing
- Request to s_stb_o: 1 cycle (registered grant).
- Slave ack/err/data to master: 0 cycles (combinational).
- Final ack to grant_o = 0: 1 cycle.
- One dead IDLE cycle always separates consecutive grants, including back-to-back requests from the same master.
- m0 requesting during a GNT1 burst waits for the full burst to finish. No preemption.
- A simultaneous ack and cyc drop in the same cycle counts as completion; the ack is forwarded.

## Configuration
- **WB_ARB_TIMEOUT_EN defined**
  - A counter clears on entering GNTx and on each s_ack_i, and increments otherwise.
  - When it reaches TIMEOUT_CYC, the arbiter pulses err to the granted master for one cycle, deasserts s_cyc_o/s_stb_o, and enters IDLE the next cycle.
- **WB_ARB_TIMEOUT_EN undefined:** no counter. The arbiter waits indefinitely for the slave.

## Structure
- **Shared package**
  - Arbiter state enum (IDLE/GNT0/GNT1).
  - Grant one-hot constants.
  - Default single-beat burst length (10'd1).
- **Sub-module `wb_rr_pick2`:** combinational two-way round-robin picker.
  - Inputs: requests and `last`.
  - Output: one-hot winner.

## Test plan
- m0 read at 0x3000_0000 alone:
  - s_stb_o rises 1 cycle after m0_stb_i.
  - Slave acks with 0xDEADBEEF: m0_ack_o=1 and m0_dat_o=0xDEADBEEF the same cycle; m1_ack_o=0.
  - grant_o=0 the next cycle.
- m1 burst, bl=4:
  - Exactly 4 acks are forwarded to m1.
  - Grant is held through all 4 and released 1 cycle after the 4th.
  - An m0 request raised mid-burst is granted only after the dead cycle.
- m0 and m1 request in the same cycle, three times in a row:
  - Grants go m0, m1, m0, with a dead cycle between each.
- m1 burst, bl=8, with s_lack_i on the 3rd ack:
  - Release after the 3rd beat.
  - beats is reloaded correctly on the next grant.
- s_err_i on beat 2 of a bl=4 burst:
  - m1_err_o pulses and grant is released.
  - m0_err_o stays 0.
  - With WB_ARB_TIMEOUT_EN and TIMEOUT_CYC=16 and no ack ever: m0_err_o pulses at cycle 16 after grant.
- Reset asserted mid-burst:
  - All outputs are 0 and grant_o=0 next cycle.
  - After reset, a tie is granted to m0.
